// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the cordic2 request scheduler.
// Holds FSM encoding, operand widths and a saturating counter helper.
package cordic_sched_pkg;

   localparam int CDC_DW = 8;
   localparam int CDC_AW = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cordic_sched_arb.sv
// Combinational round-robin arbiter.
// Grants the first requesting lane at or after ptr, wrapping cyclically.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             any
);

   function automatic int wrap(input int p, input int k);
      return (p + k) % N_REQ;
   endfunction

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!any && req[wrap(int'(ptr), k)]) begin
            gnt[wrap(int'(ptr), k)] = 1'b1;
            gnt_id = ID_W'(wrap(int'(ptr), k));
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative cordic2 engine between N_REQ requesters.
// Round-robin grant, single job in flight, watchdog abort on a stuck engine.
module cordic_sched
   import cordic_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [CDC_DW*N_REQ-1:0]   req_x,
   input  logic [CDC_DW*N_REQ-1:0]   req_y,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      resp_valid,
   output logic [ID_W-1:0]           resp_id,
   output logic [CDC_AW-1:0]         resp_angle,
   output logic                      resp_err,
   output logic [7:0]                timeout_cnt,
   output logic                      cdc_start,
   output logic [CDC_DW-1:0]         cdc_x,
   output logic [CDC_DW-1:0]         cdc_y,
   input  logic [CDC_AW-1:0]         cdc_angle,
   input  logic                      cdc_done,
   input  logic                      cdc_ready
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   state_t              r_state;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_job_id;
   logic [TW-1:0]       r_timer;
   logic [CDC_DW-1:0]   r_cdc_x;
   logic [CDC_DW-1:0]   r_cdc_y;
   logic                r_cdc_start;
   logic                r_resp_valid;
   logic [ID_W-1:0]     r_resp_id;
   logic [CDC_AW-1:0]   r_resp_angle;
   logic                r_resp_err;
   logic [7:0]          r_to_cnt;

   logic [N_REQ-1:0]    w_gnt;
   logic [ID_W-1:0]     w_gnt_id;
   logic                w_any;
   logic                w_grant;
   logic                w_expire;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req    (req_valid),
      .ptr    (r_rr_ptr),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id),
      .any    (w_any)
   );

   // Accept is a same-cycle handshake; gated so reset forces it low.
   assign w_grant   = (r_state == S_IDLE) && w_any && cdc_ready && !reset;
   assign w_expire  = (r_timer == TW'(TIMEOUT - 1));
   assign req_ready = w_grant ? w_gnt : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_job_id     <= '0;
         r_timer      <= '0;
         r_cdc_x      <= '0;
         r_cdc_y      <= '0;
         r_cdc_start  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_angle <= '0;
         r_resp_err   <= 1'b0;
         r_to_cnt     <= '0;
      end else begin
         r_cdc_start  <= 1'b0;
         r_resp_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_job_id    <= w_gnt_id;
                  r_cdc_x     <= req_x[w_gnt_id*CDC_DW +: CDC_DW];
                  r_cdc_y     <= req_y[w_gnt_id*CDC_DW +: CDC_DW];
                  r_cdc_start <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_timer <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_timer <= r_timer + TW'(1);
               // done beats an expiry landing on the same cycle
               if (cdc_done) begin
                  r_resp_angle <= cdc_angle;
                  r_resp_err   <= 1'b0;
                  r_resp_id    <= r_job_id;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (w_expire) begin
                  r_resp_angle <= '0;
                  r_resp_err   <= 1'b1;
                  r_resp_id    <= r_job_id;
                  r_resp_valid <= 1'b1;
                  r_to_cnt     <= sat_inc8(r_to_cnt);
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (r_job_id == ID_W'(N_REQ - 1))
                  r_rr_ptr <= '0;
               else
                  r_rr_ptr <= r_job_id + ID_W'(1);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cdc_start   = r_cdc_start;
   assign cdc_x       = r_cdc_x;
   assign cdc_y       = r_cdc_y;
   assign resp_valid  = r_resp_valid;
   assign resp_id     = r_resp_id;
   assign resp_angle  = r_resp_angle;
   assign resp_err    = r_resp_err;
   assign timeout_cnt = r_to_cnt;

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched with a stub engine returning {x,y}.
// Reference predicts grant order, latency, timeout and abort count.
module tb_cordic_sched;

   localparam int N  = 4;
   localparam int TO = 64;

   typedef struct {
      int          id;
      logic [15:0] angle;
      bit          err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  pend;
   logic [7:0]  lx [N];
   logic [7:0]  ly [N];
   logic [31:0] req_x, req_y;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [15:0] resp_angle;
   logic        resp_err;
   logic [7:0]  timeout_cnt;
   logic        cdc_start;
   logic [7:0]  cdc_x, cdc_y;
   logic [15:0] cdc_angle;
   logic        cdc_done;
   logic        cdc_ready;

   always #5 clk = ~clk;

   always_comb begin
      req_x = '0;
      req_y = '0;
      for (int i = 0; i < N; i++) begin
         req_x[8*i +: 8] = lx[i];
         req_y[8*i +: 8] = ly[i];
      end
   end

   cordic_sched #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (rst),
      .req_valid   (pend),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_id     (resp_id),
      .resp_angle  (resp_angle),
      .resp_err    (resp_err),
      .timeout_cnt (timeout_cnt),
      .cdc_start   (cdc_start),
      .cdc_x       (cdc_x),
      .cdc_y       (cdc_y),
      .cdc_angle   (cdc_angle),
      .cdc_done    (cdc_done),
      .cdc_ready   (cdc_ready)
   );

   int   n_chk = 0, n_err = 0;
   int   cyc = 0;
   exp_t q[$];
   int   mptr = 0, mto = 0;
   bit   [3:0] accf = '0;
   bit   reload = 0, fair = 0;
   bit   rand_lat = 0, never = 0;
   int   fix_lat = 10;
   int   job_lat = 0;
   bit   job_never = 0;
   int   eng_cnt = 0;
   int   exp_start = -1;
   logic [7:0] exp_x, exp_y;
   int   n_acc = 0, n_start = 0, last_acc = -100, last_acc_id = -1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int predict();
      for (int k = 0; k < N; k++)
         if (pend[(mptr + k) % N]) return (mptr + k) % N;
      return -1;
   endfunction

   function automatic logic [63:0] outs();
      return {15'd0, req_ready, resp_valid, resp_id, resp_angle, resp_err,
              timeout_cnt, cdc_start, cdc_x, cdc_y};
   endfunction

   // Requester side: after an accept, drop valid or load a fresh operand.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (accf[i]) begin
            accf[i] = 1'b0;
            if (reload) begin
               lx[i] = 8'($urandom);
               ly[i] = 8'($urandom);
            end else begin
               pend[i] = 1'b0;
            end
         end
      end
   end

   // Stub engine plus monitor, all sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         eng_cnt  = 0;
         cdc_done = 1'b0;
         chk("reset_zero", outs(), 64'd0);
      end else begin
         cdc_done = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) cdc_done = 1'b1;
         end
         if (cdc_start || cyc == exp_start) begin
            chk("start_cycle", {cdc_start, 32'(cyc)}, {1'b1, 32'(exp_start)});
            chk("start_xy", {cdc_x, cdc_y}, {exp_x, exp_y});
            n_start++;
            cdc_angle = {cdc_x, cdc_y};
            eng_cnt   = job_never ? 0 : job_lat;
         end
         if (req_ready != 4'd0) begin
            int p;
            int lat;
            bit to;
            exp_t e;
            p = predict();
            chk("grant", req_ready, (p >= 0) ? 64'(4'd1 << p) : 64'd0);
            if (fair && n_acc > 0)
               chk("fair_spacing", cyc - last_acc, 13);
            if (p >= 0) begin
               lat = rand_lat ? (($urandom_range(0, 7) == 0) ?
                     63 + int'($urandom_range(0, 2)) :
                     int'($urandom_range(1, 12))) : fix_lat;
               job_lat   = lat;
               job_never = never;
               to        = never || lat > TO;
               e.id      = p;
               e.err     = to;
               e.angle   = to ? 16'd0 : {lx[p], ly[p]};
               e.cyc     = cyc + 1 + (to ? TO + 1 : lat + 1);
               q.push_back(e);
               exp_start   = cyc + 1;
               exp_x       = lx[p];
               exp_y       = ly[p];
               accf[p]     = 1'b1;
               last_acc_id = p;
            end
            last_acc = cyc;
            n_acc++;
         end
         if (resp_valid) begin
            if (q.size() == 0) begin
               chk("resp_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.err && mto < 255) mto++;
               chk("resp_id", resp_id, e.id);
               chk("resp_angle", resp_angle, e.angle);
               chk("resp_err", resp_err, e.err);
               chk("resp_cycle", cyc, e.cyc);
               chk("timeout_cnt", timeout_cnt, mto);
               mptr = (e.id + 1) % N;
            end
         end else if (q.size() > 0 && cyc > q[0].cyc) begin
            chk("resp_missing", cyc, q[0].cyc);
            void'(q.pop_front());
         end
      end
   end

   task automatic raise_xy(input int i, input logic [7:0] x,
                           input logic [7:0] y);
      lx[i]   = x;
      ly[i]   = y;
      pend[i] = 1'b1;
   endtask

   task automatic raise(input int i);
      raise_xy(i, 8'($urandom), 8'($urandom));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((pend != 4'd0 || q.size() != 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) chk("idle_wait_expired", 1, 0);
   endtask

   task automatic wait_acc(input int from);
      int n;
      n = 0;
      while (n_acc == from && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) chk("accept_wait_expired", 1, 0);
   endtask

   initial begin
      int a0, s0, rise, n;
      rst       = 1'b1;
      pend      = '0;
      cdc_ready = 1'b1;
      cdc_done  = 1'b0;
      cdc_angle = '0;
      for (int i = 0; i < N; i++) begin
         lx[i] = '0;
         ly[i] = '0;
      end
      // all four requesters held from reset
      reload = 1;
      fair   = 1;
      for (int i = 0; i < N; i++) raise(i);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n = 0;
      while (n_acc < 5 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("fair_five_grants", n_acc >= 5, 1);
      reload = 0;
      fair   = 0;
      wait_idle();

      // single request, known operands
      raise_xy(2, 8'h12, 8'h34);
      wait_idle();

      // engine never answers, then a normal job
      never = 1;
      raise(1);
      wait_idle();
      never = 0;
      raise(2);
      wait_idle();

      // done on the expiry cycle, then one cycle too late
      fix_lat = 64;
      raise(3);
      wait_idle();
      fix_lat = 65;
      raise(0);
      wait_idle();
      fix_lat = 10;

      // engine busy
      cdc_ready = 1'b0;
      a0 = n_acc;
      s0 = n_start;
      raise(0);
      repeat (20) @(posedge clk);
      #1;
      chk("busy_no_accept", n_acc, a0);
      chk("busy_no_start", n_start, s0);
      cdc_ready = 1'b1;
      rise = cyc + 1;
      wait_acc(a0);
      chk("busy_accept_cycle", last_acc, rise);
      wait_idle();

      // reset while a job sits in WAIT
      s0 = n_start;
      raise(1);
      n = 0;
      while (n_start == s0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reset_job_started", n_start != s0, 1);
      raise(0);
      raise(3);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      q.delete();
      mptr      = 0;
      mto       = 0;
      exp_start = -1;
      #1 chk("reset_async_zero", outs(), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      a0 = n_acc;
      wait_acc(a0);
      chk("reset_grant_lowest", last_acc_id, 0);
      wait_idle();

      // random traffic
      rand_lat = 1;
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) raise(i);
         repeat ($urandom_range(1, 40)) @(posedge clk);
         #1;
      end
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
